// File: rtl/sram_pkg.sv
// Shared definitions for the line SRAM fill/read path: default geometry,
// line packing helpers and the loader state encoding seen by the reader.
package sram_pkg;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 256;
  localparam int IN_WIDTH_DEF   = 32;

  // Number of input words packed into one SRAM line.
  function automatic int words_per_line(input int data_width, input int in_width);
    return data_width / in_width;
  endfunction

  // Width of a counter that indexes the word slots of a line (at least 1 bit).
  function automatic int slot_cnt_width(input int wpl);
    return (wpl > 1) ? $clog2(wpl) : 1;
  endfunction

  // Loader state encoding; the downstream reader decodes these values.
  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_FILL = 2'd1,
    LD_LAST = 2'd2,
    LD_DONE = 2'd3
  } loader_state_e;

endpackage

// File: rtl/word_packer.sv
// Collects narrow input words into a full-width line. The line output already
// contains the word being accepted this cycle, so the parent can register the
// complete line on the same edge that accepts its final word.
module word_packer
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IN_WIDTH   = IN_WIDTH_DEF
) (
  input  logic                  clka,
  input  logic                  reset,
  input  logic                  accept,
  input  logic [IN_WIDTH-1:0]   word,
  output logic [DATA_WIDTH-1:0] line,
  output logic                  line_full
);

  localparam int WORDS_PER_LINE = words_per_line(DATA_WIDTH, IN_WIDTH);
  localparam int WCNT_W         = slot_cnt_width(WORDS_PER_LINE);
  localparam logic [WCNT_W-1:0] LAST_SLOT = WCNT_W'(WORDS_PER_LINE - 1);

  logic [WCNT_W-1:0]     word_cnt_r;
  logic [DATA_WIDTH-1:0] buf_r;
  logic [DATA_WIDTH-1:0] line_s;
  logic                  at_last_slot_s;

  assign at_last_slot_s = (word_cnt_r == LAST_SLOT);
  assign line_full      = accept && at_last_slot_s;
  assign line           = line_s;

  // Merge the incoming word into its slot on top of the buffered words.
  always_comb begin
    line_s = buf_r;
    line_s[int'(word_cnt_r) * IN_WIDTH +: IN_WIDTH] = word;
  end

  // Slot counter: advances per accepted word and wraps after the last slot.
  always_ff @(posedge clka) begin
    if (reset) begin
      word_cnt_r <= '0;
    end else if (accept) begin
      word_cnt_r <= at_last_slot_s ? '0 : (word_cnt_r + WCNT_W'(1));
    end
  end

  // Line buffer: stores each accepted word in its slot.
  always_ff @(posedge clka) begin
    if (reset) begin
      buf_r <= '0;
    end else if (accept) begin
      buf_r <= line_s;
    end
  end

endmodule

// File: rtl/sram_line_loader.sv
// Fill stage for write port A of the line SRAM. Packs a word stream into
// lines and writes num_lines consecutive lines from base_addr, then pulses
// done. Runs entirely on clka.
module sram_line_loader
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IN_WIDTH   = IN_WIDTH_DEF
) (
  input  logic                  clka,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_lines,
  input  logic                  s_valid,
  input  logic [IN_WIDTH-1:0]   s_data,
  output logic                  s_ready,
  output logic                  ena,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dina,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] ONE_LINE = (ADDR_WIDTH + 1)'(1);

  loader_state_e         state_r;
  loader_state_e         next_state_s;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH:0]   num_r;
  logic [ADDR_WIDTH:0]   line_cnt_r;
  logic                  accept_s;
  logic                  line_full_s;
  logic                  last_line_s;
  logic                  start_ok_s;
  logic [DATA_WIDTH-1:0] line_s;
  logic                  wea_r;
  logic [ADDR_WIDTH-1:0] addra_r;
  logic [DATA_WIDTH-1:0] dina_r;
  logic                  busy_r;
  logic                  done_r;

  // Words are only taken while filling; the rest of the time the stream stalls.
  assign s_ready     = (state_r == LD_FILL);
  assign accept_s    = s_valid && s_ready;
  assign start_ok_s  = start && (state_r == LD_IDLE);
  assign last_line_s = (line_cnt_r == (num_r - ONE_LINE));

  assign ena   = wea_r;
  assign wea   = wea_r;
  assign addra = addra_r;
  assign dina  = dina_r;
  assign busy  = busy_r;
  assign done  = done_r;

  word_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_WIDTH   (IN_WIDTH)
  ) u_word_packer (
    .clka      (clka),
    .reset     (reset),
    .accept    (accept_s),
    .word      (s_data),
    .line      (line_s),
    .line_full (line_full_s)
  );

  // Next-state decode for the load sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      LD_IDLE: begin
        if (start) begin
          if (num_lines != '0) begin
            next_state_s = LD_FILL;
          end else begin
            next_state_s = LD_DONE;
          end
        end else begin
          next_state_s = LD_IDLE;
        end
      end
      LD_FILL: begin
        if (line_full_s && last_line_s) begin
          next_state_s = LD_LAST;
        end else begin
          next_state_s = LD_FILL;
        end
      end
      LD_LAST: next_state_s = LD_DONE;
      LD_DONE: next_state_s = LD_IDLE;
      default: next_state_s = LD_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clka) begin
    if (reset) begin
      state_r <= LD_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Load parameters are captured only on an accepted start; lines are counted as they complete.
  always_ff @(posedge clka) begin
    if (reset) begin
      base_r     <= '0;
      num_r      <= '0;
      line_cnt_r <= '0;
    end else if (start_ok_s) begin
      base_r     <= base_addr;
      num_r      <= num_lines;
      line_cnt_r <= '0;
    end else if (line_full_s) begin
      line_cnt_r <= line_cnt_r + ONE_LINE;
    end
  end

  // SRAM port registers: one write strobe per completed line; address/data hold otherwise.
  always_ff @(posedge clka) begin
    if (reset) begin
      wea_r   <= 1'b0;
      addra_r <= '0;
      dina_r  <= '0;
    end else begin
      wea_r <= line_full_s;
      if (line_full_s) begin
        addra_r <= base_r + line_cnt_r[ADDR_WIDTH-1:0];
        dina_r  <= line_s;
      end
    end
  end

  // Status outputs registered from the upcoming state so they line up with it.
  always_ff @(posedge clka) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s != LD_IDLE);
      done_r <= (next_state_s == LD_DONE);
    end
  end

endmodule

// File: tb/tb_sram_line_loader.sv
// Self-checking bench for sram_line_loader (256-bit lines, 32-bit words,
// 10-bit addresses). A negedge monitor logs every write and done pulse; each
// load is compared against a word-list model of what the SRAM should receive.
module tb_sram_line_loader;

  logic         clka = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [9:0]   base_addr = 10'd0;
  logic [10:0]  num_lines = 11'd0;
  logic         s_valid = 1'b0;
  logic [31:0]  s_data = 32'd0;
  logic         s_ready;
  logic         ena;
  logic         wea;
  logic [9:0]   addra;
  logic [255:0] dina;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int           wr_addr_q[$];
  logic [255:0] wr_data_q[$];
  int           wr_cyc_q[$];
  int           done_cyc_q[$];
  int           ready_cnt = 0;
  int           ena_bad = 0;
  int           hold_bad = 0;
  logic [9:0]   addra_prev = 10'd0;
  logic [255:0] dina_prev = 256'd0;
  logic         reset_prev = 1'b1;

  sram_line_loader dut (
    .clka      (clka),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_lines (num_lines),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .busy      (busy),
    .done      (done)
  );

  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  // Monitor: log SRAM writes and done pulses, watch enable/strobe agreement and hold behaviour.
  always @(negedge clka) begin
    if (wea) begin
      wr_addr_q.push_back(int'(addra));
      wr_data_q.push_back(dina);
      wr_cyc_q.push_back(cyc);
    end
    if (done) done_cyc_q.push_back(cyc);
    if (s_ready) ready_cnt <= ready_cnt + 1;
    if (ena != wea) ena_bad <= ena_bad + 1;
    if (!wea && !reset && !reset_prev && (addra != addra_prev || dina != dina_prev))
      hold_bad <= hold_bad + 1;
    addra_prev <= addra;
    dina_prev  <= dina;
    reset_prev <= reset;
  end

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: line i is words 8i..8i+7 with the earliest word in the low bits.
  function automatic logic [255:0] pack_line(input int unsigned w[$], input int line_idx);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = w[line_idx*8 + k];
    return d;
  endfunction

  task automatic check_all_zero(input string tag);
    check_int({tag, "_s_ready"}, int'(s_ready), 0);
    check_int({tag, "_ena"}, int'(ena), 0);
    check_int({tag, "_wea"}, int'(wea), 0);
    check_int({tag, "_addra"}, int'(addra), 0);
    check_vec({tag, "_dina"}, dina, 256'd0);
    check_int({tag, "_busy"}, int'(busy), 0);
    check_int({tag, "_done"}, int'(done), 0);
  endtask

  // One complete load: start, feed words (with random gaps), wait for done, compare to model.
  task automatic run_load(input int base, input int num, input int gap, input bit seq,
                          input bit midstart, output int first_addr, output int last_addr,
                          output int n_wr);
    int unsigned words[$];
    int acc_cyc[$];
    int total, idx, budget, start_cyc, w0, d0, r0, waited, consec;
    bit rdy, v, ms_done;
    total = num * 8;
    consec = 0;
    for (int i = 0; i < total; i++) words.push_back(seq ? int'(i + 1) : $urandom);
    w0 = wr_addr_q.size();
    d0 = done_cyc_q.size();
    r0 = ready_cnt;

    start = 1'b1; base_addr = 10'(base); num_lines = 11'(num);
    step();
    start = 1'b0; start_cyc = cyc;
    base_addr = 10'($urandom); num_lines = 11'($urandom);
    check_int("busy_after_start", int'(busy), 1);
    check_int("ready_after_start", int'(s_ready), (num != 0) ? 1 : 0);

    idx = 0; budget = 0; ms_done = 1'b0;
    while (idx < total && budget < total * 20 + 50) begin
      rdy = s_ready;
      v = ($urandom_range(99) >= gap);
      if (midstart && !ms_done && idx >= 4) begin
        start = 1'b1; base_addr = 10'd777; num_lines = 11'd1; ms_done = 1'b1;
      end
      s_valid = v;
      s_data  = v ? words[idx] : $urandom;
      step();
      start = 1'b0;
      if (v && rdy) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      budget++;
    end
    s_valid = 1'b0;
    if (idx < total) check_int("feed_timeout", idx, total);

    waited = 0;
    while (done_cyc_q.size() == d0 && waited < 20) begin
      step();
      waited++;
    end
    repeat (4) step();

    n_wr = wr_addr_q.size() - w0;
    check_int("write_count", n_wr, num);
    check_int("done_count", done_cyc_q.size() - d0, 1);
    first_addr = (n_wr > 0) ? wr_addr_q[w0] : -1;
    last_addr  = (n_wr > 0) ? wr_addr_q[w0 + n_wr - 1] : -1;
    for (int i = 0; i < n_wr && i < num; i++) begin
      check_int($sformatf("addr_line%0d", i), wr_addr_q[w0 + i], (base + i) % 1024);
      check_vec($sformatf("data_line%0d", i), wr_data_q[w0 + i], pack_line(words, i));
      if (8 * i + 7 < acc_cyc.size())
        check_int($sformatf("wea_latency_line%0d", i), wr_cyc_q[w0 + i], acc_cyc[8 * i + 7]);
      if (i > 0 && wr_cyc_q[w0 + i] - wr_cyc_q[w0 + i - 1] == 1) consec++;
    end
    check_int("no_back_to_back_wea", consec, 0);
    if (done_cyc_q.size() > d0) begin
      if (num == 0) check_int("done_latency_zero_lines", done_cyc_q[d0], start_cyc);
      else if (n_wr > 0) check_int("done_latency", done_cyc_q[d0], wr_cyc_q[w0 + n_wr - 1] + 1);
    end
    if (num == 0) check_int("ready_zero_lines", ready_cnt - r0, 0);
    check_int("busy_idle_end", int'(busy), 0);
    check_int("ready_idle_end", int'(s_ready), 0);
  endtask

  typedef struct {
    int base;
    int num;
    int gap;
    bit seq;
    bit midstart;
    int exp_writes;
    int exp_first_addr;
    int exp_last_addr;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int fa, la, nw, wtmp, w0;

    vecs[0] = '{base: 5,    num: 2, gap: 0,  seq: 1'b1, midstart: 1'b0, exp_writes: 2, exp_first_addr: 5,    exp_last_addr: 6};
    vecs[1] = '{base: 5,    num: 2, gap: 50, seq: 1'b1, midstart: 1'b0, exp_writes: 2, exp_first_addr: 5,    exp_last_addr: 6};
    vecs[2] = '{base: 300,  num: 0, gap: 0,  seq: 1'b0, midstart: 1'b0, exp_writes: 0, exp_first_addr: -1,   exp_last_addr: -1};
    vecs[3] = '{base: 1023, num: 2, gap: 0,  seq: 1'b0, midstart: 1'b0, exp_writes: 2, exp_first_addr: 1023, exp_last_addr: 0};
    vecs[4] = '{base: 200,  num: 3, gap: 20, seq: 1'b0, midstart: 1'b1, exp_writes: 3, exp_first_addr: 200,  exp_last_addr: 202};
    vecs[5] = '{base: 1020, num: 6, gap: 10, seq: 1'b0, midstart: 1'b0, exp_writes: 6, exp_first_addr: 1020, exp_last_addr: 1};

    // Power-on reset: every output low.
    reset = 1'b1;
    repeat (3) step();
    check_all_zero("reset_state");
    reset = 1'b0;
    step();

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      wtmp = wr_addr_q.size();
      run_load(vecs[i].base, vecs[i].num, vecs[i].gap, vecs[i].seq, vecs[i].midstart, fa, la, nw);
      check_int($sformatf("vec%0d_writes", i), nw, vecs[i].exp_writes);
      check_int($sformatf("vec%0d_first_addr", i), fa, vecs[i].exp_first_addr);
      check_int($sformatf("vec%0d_last_addr", i), la, vecs[i].exp_last_addr);
      if (i == 0 && wr_data_q.size() > wtmp)
        check_vec("first_line_literal", wr_data_q[wtmp],
                  256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
      repeat (2) step();
    end

    // Reset in the middle of a line: load is abandoned, nothing written.
    w0 = wr_addr_q.size();
    start = 1'b1; base_addr = 10'd40; num_lines = 11'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hA0 + 32'(i);
      step();
    end
    s_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("mid_reset");
    repeat (3) step();
    check_int("mid_reset_no_wea", wr_addr_q.size() - w0, 0);
    run_load(40, 1, 0, 1'b1, 1'b0, fa, la, nw);
    check_int("after_reset_addr", fa, 40);

    // Randomized loads against the model.
    for (int r = 0; r < 6; r++) begin
      run_load(int'($urandom_range(1023)), int'($urandom_range(1, 4)), int'($urandom_range(0, 60)),
               1'b0, 1'($urandom_range(1)), fa, la, nw);
      step();
    end

    check_int("ena_equals_wea", ena_bad, 0);
    check_int("addr_data_hold", hold_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
